// File: rtl/cex_controller.sv
// XM23 conditional-execution window sequencer: latches the CEX condition, counts
// the T and F slots that follow and gates the execute stage for skipped instructions.
module cex_controller #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic             cex_en,
    input  logic [3:0]       cex_cond,
    input  logic [CNT_W-1:0] cex_t,
    input  logic [CNT_W-1:0] cex_f,
    input  logic             psw_n,
    input  logic             psw_z,
    input  logic             psw_c,
    input  logic             psw_v,
    input  logic             flush,
    output logic             exec_en,
    output logic             cex_active,
    output logic             cex_phase,
    output logic [CNT_W-1:0] cex_remain
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        T_PH = 2'd1,
        F_PH = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] f_q, f_n;
    logic             cond_q, cond_n;
    logic             cc_true;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Condition evaluation against the live flags; only consumed in the CEX cycle.
    always_comb begin
        cc_true = 1'b0;
        case (cex_cond)
            4'd0:  cc_true = psw_z;
            4'd1:  cc_true = !psw_z;
            4'd2:  cc_true = psw_c;
            4'd3:  cc_true = !psw_c;
            4'd4:  cc_true = psw_n;
            4'd5:  cc_true = !psw_n;
            4'd6:  cc_true = psw_v;
            4'd7:  cc_true = !psw_v;
            4'd8:  cc_true = psw_c && !psw_z;
            4'd9:  cc_true = !psw_c || psw_z;
            4'd10: cc_true = (psw_n == psw_v);
            4'd11: cc_true = (psw_n != psw_v);
            4'd12: cc_true = !psw_z && (psw_n == psw_v);
            4'd13: cc_true = psw_z || (psw_n != psw_v);
            4'd14: cc_true = 1'b1;
            default: cc_true = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            f_q    <= '0;
            cond_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            f_q    <= f_n;
            cond_q <= cond_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        f_n     = f_q;
        cond_n  = cond_q;
        if (flush) begin
            state_n = IDLE;
            cnt_n   = '0;
            f_n     = '0;
            cond_n  = 1'b0;
        end else if (instr_valid) begin
            case (state)
                IDLE: begin
                    if (cex_en) begin
                        cond_n = cc_true;
                        f_n    = cex_f;
                        if (cex_t != '0) begin
                            state_n = T_PH;
                            cnt_n   = cex_t;
                        end else if (cex_f != '0) begin
                            state_n = F_PH;
                            cnt_n   = cex_f;
                        end
                    end
                end
                // A nested CEX simply consumes a slot here; it never reloads the window.
                T_PH: begin
                    if (cnt == CNT_ONE) begin
                        if (f_q != '0) begin
                            state_n = F_PH;
                            cnt_n   = f_q;
                        end else begin
                            state_n = IDLE;
                            cnt_n   = '0;
                        end
                    end else begin
                        cnt_n = cnt - CNT_ONE;
                    end
                end
                F_PH: begin
                    if (cnt == CNT_ONE) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt - CNT_ONE;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_comb begin
        exec_en = 1'b0;
        if (instr_valid && !flush) begin
            case (state)
                IDLE:    exec_en = !cex_en;
                T_PH:    exec_en = !cex_en && cond_q;
                F_PH:    exec_en = !cex_en && !cond_q;
                default: exec_en = 1'b0;
            endcase
        end
    end

    assign cex_active = (state != IDLE);
    assign cex_phase  = (state == F_PH);
    assign cex_remain = cnt;

endmodule
